square_motion_controller: RTL and testbench
===========================================

// Module: square_motion_controller
// PURPOSE
// Frame-synchronous controller for the 480p square-pattern painter. Owns the square position
// (bouncing motion) and the active colour scheme, and exposes a command handshake for pause,
// scheme change and recentre. All state changes occur only on the frame-start pulse from
// Video_Signal_Generator, so the painter never sees a mid-frame change (no tearing).
// Sits in the pixel-clock domain, between the signal generator and the pixel paint logic.
// PARAMETERS
// COORD_BITS   10   width of all coordinate ports
// COLOUR_BITS  8    width of each colour channel
// H_RES        640  active width in pixels
// V_RES        480  active height in lines
// SQ_SIZE      200  square edge length in pixels; must be < V_RES
// STEP         2    pixels moved per frame on each axis; must be >= 1 and < (V_RES-SQ_SIZE)
// PORTS
// i_clk          in   1            pixel clock (25 MHz)
// i_rst          in   1            synchronous, active-high reset
// i_frame_start  in   1            1-cycle pulse, once per frame (generator o_nf)
// i_cmd_valid    in   1            command valid
// i_cmd          in   2            00 NOP, 01 pause toggle, 10 next scheme, 11 recentre
// o_cmd_ready    out  1            command slot free
// o_sq_x0/o_sq_x1 out COORD_BITS   square left/right column, inclusive
// o_sq_y0/o_sq_y1 out COORD_BITS   square top/bottom line, inclusive
// o_fg_r/g/b     out  COLOUR_BITS  colour inside square
// o_bg_r/g/b     out  COLOUR_BITS  colour outside square
// o_running      out  1            1 = moving, 0 = paused
// BEHAVIOUR
// - Reset values: x=XC=(H_RES-SQ_SIZE)/2, y=YC=(V_RES-SQ_SIZE)/2, dx=+, dy=+, scheme 0,
//   o_running=1, pending slot empty, o_cmd_ready=1. Reset mid-operation discards any pending command.
// - Outputs registered: x0=x, x1=x+SQ_SIZE-1, y0=y, y1=y+SQ_SIZE-1; fg/bg decoded from scheme.
// - Handshake: command accepted when i_cmd_valid && o_cmd_ready; it is stored in a 1-entry pending
//   slot and o_cmd_ready=0 from the next cycle until the slot is consumed. NOP is accepted and
//   consumed with no effect. i_cmd_valid while o_cmd_ready=0 is ignored (not queued).
// - On i_frame_start: (1) apply the pending command, if any, and clear the slot (o_cmd_ready=1 the next
//   cycle); (2) if running and the command was not recentre, step the motion. A command accepted on
//   the same cycle as i_frame_start is applied at the following frame start.
// - Pause toggle inverts o_running; the step in (2) uses the new value.
// - Next scheme: scheme = (scheme+1) mod 4, wraps 3->0. Schemes (fg / bg, RGB hex):
//   0 FFFFFF/00008B, 1 000000/FFFFFF, 2 FF0000/000000, 3 FFFF00/006400.
// - Recentre: x=XC, y=YC, dx=dy=+, no step that frame; scheme and o_running unchanged.
// - Motion per axis (x shown, y identical with V_RES): XMAX=H_RES-SQ_SIZE.
//   dx=+: if x+STEP >= XMAX then x=XMAX, dx=- else x=x+STEP.
//   dx=-: if x <= STEP then x=0, dx=+ else x=x-STEP.
//   Clamped, so the square never leaves the active area; no underflow or overflow of x.
// - Latency: new outputs are visible one cycle after the i_frame_start cycle; stable otherwise.
// TESTING
// 1 Reset -> x0=220 x1=419 y0=140 y1=339, fg FFFFFF, bg 00008B, ready=1, running=1.
// 2 3 frame_starts, no cmd -> x0=226 y0=146; outputs unchanged between pulses.
// 3 110 frame_starts -> x0=440 (dx flips), y0=200 (y bounced at 280 after frame 70);
//   frame 111 -> x0=438, y0=198.
// 4 cmd 10 mid-frame -> ready=0 next cycle, second cmd ignored; colours unchanged until frame_start,
//   then fg 000000 bg FFFFFF, ready=1; 4 x (cmd 10) from scheme 0 -> scheme 0 again (wrap).
// 5 cmd 01 -> running=0 after frame_start, position frozen over 5 pulses; cmd 01 -> motion resumes
//   on that same pulse (+STEP).
// 6 cmd 11 after 50 frames -> x0=220 y0=140 on that pulse; next pulse 222/142. Reset with a pending
//   cmd -> reset values, pending cmd never applied.

Source files
------------

// File: rtl/square_motion_controller.sv
// ============================================================================
// square_motion_controller
// Frame-synchronous square position/colour-scheme controller with a command slot.
// Rev 1.0
// ============================================================================
`default_nettype none

module square_motion_controller #(
  parameter int COORD_BITS  = 10,
  parameter int COLOUR_BITS = 8,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SQ_SIZE     = 200,
  parameter int STEP        = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_frame_start,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd,
  output logic                   o_cmd_ready,
  output logic [COORD_BITS-1:0]  o_sq_x0,
  output logic [COORD_BITS-1:0]  o_sq_x1,
  output logic [COORD_BITS-1:0]  o_sq_y0,
  output logic [COORD_BITS-1:0]  o_sq_y1,
  output logic [COLOUR_BITS-1:0] o_fg_r,
  output logic [COLOUR_BITS-1:0] o_fg_g,
  output logic [COLOUR_BITS-1:0] o_fg_b,
  output logic [COLOUR_BITS-1:0] o_bg_r,
  output logic [COLOUR_BITS-1:0] o_bg_g,
  output logic [COLOUR_BITS-1:0] o_bg_b,
  output logic                   o_running
);

  localparam logic [COORD_BITS-1:0] C_XC   = COORD_BITS'((H_RES - SQ_SIZE) / 2);
  localparam logic [COORD_BITS-1:0] C_YC   = COORD_BITS'((V_RES - SQ_SIZE) / 2);
  localparam logic [COORD_BITS-1:0] C_XMAX = COORD_BITS'(H_RES - SQ_SIZE);
  localparam logic [COORD_BITS-1:0] C_YMAX = COORD_BITS'(V_RES - SQ_SIZE);
  localparam logic [COORD_BITS-1:0] C_STEP = COORD_BITS'(STEP);
  localparam logic [COORD_BITS-1:0] C_SQM1 = COORD_BITS'(SQ_SIZE - 1);

  localparam logic [1:0] CMD_NOP      = 2'b00;
  localparam logic [1:0] CMD_PAUSE    = 2'b01;
  localparam logic [1:0] CMD_NEXT     = 2'b10;
  localparam logic [1:0] CMD_RECENTRE = 2'b11;

  localparam logic [COLOUR_BITS-1:0] C_FULL = '1;
  localparam logic [COLOUR_BITS-1:0] C_ZERO = '0;
  localparam logic [COLOUR_BITS-1:0] C_DB   = COLOUR_BITS'(8'h8B);
  localparam logic [COLOUR_BITS-1:0] C_DG   = COLOUR_BITS'(8'h64);

  localparam int CW = 3 * COLOUR_BITS;

  // Returns {dir, pos}; dir=1 means moving towards larger coordinates.
  function automatic logic [COORD_BITS:0] step_axis(
    input logic [COORD_BITS-1:0] pos,
    input logic                  dir_pos,
    input logic [COORD_BITS-1:0] lim
  );
    logic [COORD_BITS:0] ext;
    ext = {1'b0, pos} + {1'b0, C_STEP};
    if (dir_pos) begin
      if (ext >= {1'b0, lim}) return {1'b0, lim};
      else                    return {1'b1, ext[COORD_BITS-1:0]};
    end else begin
      if (pos <= C_STEP) return {1'b1, {COORD_BITS{1'b0}}};
      else               return {1'b0, pos - C_STEP};
    end
  endfunction

  function automatic logic [2*CW-1:0] scheme_colours(input logic [1:0] s);
    case (s)
      2'd0:    return {C_FULL, C_FULL, C_FULL, C_ZERO, C_ZERO, C_DB};
      2'd1:    return {C_ZERO, C_ZERO, C_ZERO, C_FULL, C_FULL, C_FULL};
      2'd2:    return {C_FULL, C_ZERO, C_ZERO, C_ZERO, C_ZERO, C_ZERO};
      default: return {C_FULL, C_FULL, C_ZERO, C_ZERO, C_DG, C_ZERO};
    endcase
  endfunction

  logic [COORD_BITS-1:0] x_q, x_d, y_q, y_d;
  logic                  dx_q, dx_d, dy_q, dy_d;
  logic [1:0]            scheme_q, scheme_d;
  logic                  running_q, running_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [1:0]            pend_cmd_q, pend_cmd_d;
  logic                  recentre_w;
  logic                  accept_w;

  logic [COORD_BITS-1:0] x0_q, x1_q, y0_q, y1_q;
  logic [CW-1:0]         fg_q, bg_q;

  assign accept_w = i_cmd_valid && !pend_valid_q;

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    scheme_d     = scheme_q;
    running_d    = running_q;
    pend_valid_d = pend_valid_q;
    pend_cmd_d   = pend_cmd_q;
    recentre_w   = 1'b0;

    if (i_frame_start) begin
      pend_valid_d = 1'b0;
      if (pend_valid_q) begin
        case (pend_cmd_q)
          CMD_PAUSE: running_d = !running_q;
          CMD_NEXT:  scheme_d  = scheme_q + 2'd1;
          CMD_RECENTRE: begin
            x_d        = C_XC;
            y_d        = C_YC;
            dx_d       = 1'b1;
            dy_d       = 1'b1;
            recentre_w = 1'b1;
          end
          default: ;
        endcase
      end
      // Stepping honours a pause toggle applied on this same frame.
      if (running_d && !recentre_w) begin
        {dx_d, x_d} = step_axis(x_q, dx_q, C_XMAX);
        {dy_d, y_d} = step_axis(y_q, dy_q, C_YMAX);
      end
    end

    // A command landing with frame_start fills the just-emptied slot for next frame.
    if (accept_w) begin
      pend_valid_d = 1'b1;
      pend_cmd_d   = i_cmd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q          <= C_XC;
      y_q          <= C_YC;
      dx_q         <= 1'b1;
      dy_q         <= 1'b1;
      scheme_q     <= 2'd0;
      running_q    <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= CMD_NOP;
      x0_q         <= C_XC;
      x1_q         <= C_XC + C_SQM1;
      y0_q         <= C_YC;
      y1_q         <= C_YC + C_SQM1;
      {fg_q, bg_q} <= scheme_colours(2'd0);
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      scheme_q     <= scheme_d;
      running_q    <= running_d;
      pend_valid_q <= pend_valid_d;
      pend_cmd_q   <= pend_cmd_d;
      x0_q         <= x_d;
      x1_q         <= x_d + C_SQM1;
      y0_q         <= y_d;
      y1_q         <= y_d + C_SQM1;
      {fg_q, bg_q} <= scheme_colours(scheme_d);
    end
  end

  assign o_cmd_ready = !pend_valid_q;
  assign o_running   = running_q;
  assign o_sq_x0     = x0_q;
  assign o_sq_x1     = x1_q;
  assign o_sq_y0     = y0_q;
  assign o_sq_y1     = y1_q;
  assign {o_fg_r, o_fg_g, o_fg_b} = fg_q;
  assign {o_bg_r, o_bg_g, o_bg_b} = bg_q;

endmodule

`default_nettype wire

// File: tb/tb_square_motion_controller.sv
// ============================================================================
// tb_square_motion_controller
// Scoreboard bench: directed stimulus queues expectations, a monitor compares.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_square_motion_controller;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic [9:0] x0, x1, y0, y1;
  logic [7:0] fg_r, fg_g, fg_b, bg_r, bg_g, bg_b;
  logic       running;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         x0;
    int         y0;
    logic [1:0] scheme;
    logic       run;
    logic       rdy;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  square_motion_controller dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_start (frame_start),
    .i_cmd_valid   (cmd_valid),
    .i_cmd         (cmd),
    .o_cmd_ready   (cmd_ready),
    .o_sq_x0       (x0),
    .o_sq_x1       (x1),
    .o_sq_y0       (y0),
    .o_sq_y1       (y1),
    .o_fg_r        (fg_r),
    .o_fg_g        (fg_g),
    .o_fg_b        (fg_b),
    .o_bg_r        (bg_r),
    .o_bg_g        (bg_g),
    .o_bg_b        (bg_b),
    .o_running     (running)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic logic [23:0] fg_of(input logic [1:0] s);
    case (s)
      2'd0:    return 24'hFFFFFF;
      2'd1:    return 24'h000000;
      2'd2:    return 24'hFF0000;
      default: return 24'hFFFF00;
    endcase
  endfunction

  function automatic logic [23:0] bg_of(input logic [1:0] s);
    case (s)
      2'd0:    return 24'h00008B;
      2'd1:    return 24'hFFFFFF;
      2'd2:    return 24'h000000;
      default: return 24'h006400;
    endcase
  endfunction

  task automatic cmp(input string tag, input string field, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, field, act, req);
    end
  endtask

  // Monitor: outputs settle after each rising edge; compare all queued expectations.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.tag, "x0",    int'(x0), e.x0);
        cmp(e.tag, "x1",    int'(x1), e.x0 + 199);
        cmp(e.tag, "y0",    int'(y0), e.y0);
        cmp(e.tag, "y1",    int'(y1), e.y0 + 199);
        cmp(e.tag, "fg",    int'({fg_r, fg_g, fg_b}), int'(fg_of(e.scheme)));
        cmp(e.tag, "bg",    int'({bg_r, bg_g, bg_b}), int'(bg_of(e.scheme)));
        cmp(e.tag, "run",   int'(running), int'(e.run));
        cmp(e.tag, "ready", int'(cmd_ready), int'(e.rdy));
      end
    end
  end

  task automatic expect_st(input string tag, input int ex, input int ey,
                           input logic [1:0] s, input logic run, input logic rdy);
    exp_t e;
    @(negedge clk);
    e.x0 = ex; e.y0 = ey; e.scheme = s; e.run = run; e.rdy = rdy; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; frame_start = 1'b0; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_cmd(input logic [1:0] c);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c;
    @(negedge clk);
    cmd_valid = 1'b0; cmd = 2'b00;
  endtask

  task automatic cmd_frame(input logic [1:0] c);
    send_cmd(c);
    frames(1);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not complete, expected end before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; cmd_valid = 1'b0; cmd = 2'b00;

    do_reset();
    expect_st("reset", 220, 140, 2'd0, 1'b1, 1'b1);

    frames(3);
    expect_st("three_frames", 226, 146, 2'd0, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    expect_st("stable", 226, 146, 2'd0, 1'b1, 1'b1);

    do_reset();
    frames(110);
    expect_st("bounce_110", 440, 200, 2'd0, 1'b1, 1'b1);
    frames(1);
    expect_st("bounce_111", 438, 198, 2'd0, 1'b1, 1'b1);
    cmd_frame(2'b11);
    expect_st("recentre_rev", 220, 140, 2'd0, 1'b1, 1'b1);
    frames(1);
    expect_st("after_recentre_rev", 222, 142, 2'd0, 1'b1, 1'b1);

    // Scheme change; a second command while busy must be dropped.
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 2'b10;
    @(negedge clk);
    cmd = 2'b01;
    @(negedge clk);
    cmd_valid = 1'b0; cmd = 2'b00;
    expect_st("pending", 220, 140, 2'd0, 1'b1, 1'b0);
    frames(1);
    expect_st("scheme1", 222, 142, 2'd1, 1'b1, 1'b1);
    cmd_frame(2'b10);
    expect_st("scheme2", 224, 144, 2'd2, 1'b1, 1'b1);
    cmd_frame(2'b10);
    expect_st("scheme3", 226, 146, 2'd3, 1'b1, 1'b1);
    cmd_frame(2'b10);
    expect_st("scheme_wrap", 228, 148, 2'd0, 1'b1, 1'b1);
    cmd_frame(2'b00);
    expect_st("nop", 230, 150, 2'd0, 1'b1, 1'b1);

    cmd_frame(2'b01);
    expect_st("paused", 230, 150, 2'd0, 1'b0, 1'b1);
    frames(5);
    expect_st("paused_5", 230, 150, 2'd0, 1'b0, 1'b1);
    cmd_frame(2'b01);
    expect_st("resumed", 232, 152, 2'd0, 1'b1, 1'b1);

    do_reset();
    frames(50);
    expect_st("fifty", 320, 240, 2'd0, 1'b1, 1'b1);
    cmd_frame(2'b11);
    expect_st("recentre", 220, 140, 2'd0, 1'b1, 1'b1);
    frames(1);
    expect_st("after_recentre", 222, 142, 2'd0, 1'b1, 1'b1);

    send_cmd(2'b10);
    do_reset();
    expect_st("reset_drops", 220, 140, 2'd0, 1'b1, 1'b1);
    frames(1);
    expect_st("reset_drops_frame", 222, 142, 2'd0, 1'b1, 1'b1);

    // Command accepted on the frame_start cycle waits for the next frame.
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 2'b10; frame_start = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd = 2'b00; frame_start = 1'b0;
    expect_st("same_cycle", 224, 144, 2'd0, 1'b1, 1'b0);
    frames(1);
    expect_st("same_cycle_next", 226, 146, 2'd1, 1'b1, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
